ahb_sram_subordinate: RTL

AHB_SRAM_SUBORDINATE -- requirements
Module: ahb_sram_subordinate

---
 rtl/ahb_sram_subordinate.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ahb_sram_subordinate.sv
// rtl/ahb_sram_subordinate.sv - AHB-Lite SRAM subordinate with optional wait states and error responses
module ahb_sram_subordinate #(
    parameter int          MEM_WORDS   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            live_q, live_d;
    logic [AW-1:0]   word_q;
    logic [1:0]      lane_q;
    logic [2:0]      size_q;
    logic            write_q;
    logic [31:0]     mem [MEM_WORDS];

    logic [31:0]     offset;
    logic            addr_err;
    logic            accept;
    logic            ready_c;
    logic            resp_c;
    logic            do_write;
    logic [3:0]      be;
    logic            unused_bits;

    assign offset = HADDR - BASE_ADDR;
    assign addr_err = (HSIZE > 3'd2)
                   || (HSIZE == 3'd1 && HADDR[0])
                   || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
                   || (offset[31:AW+2] != '0);
    assign unused_bits = ^{HBURST, HTRANS[0], size_q[2]};

    // A new address phase can only be taken when this cycle ends our own data phase.
    always_comb begin
        ready_c = 1'b1;
        resp_c  = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        live_d  = 1'b0;
        case (state_q)
            S_WAIT:  ready_c = (cnt_q == 4'd0);
            S_ERR1:  begin ready_c = 1'b0; resp_c = 1'b1; end
            S_ERR2:  resp_c = 1'b1;
            default: ;
        endcase
        accept = HSEL && HREADY && HTRANS[1] && ready_c;
        if (accept) begin
            if (addr_err) begin
                state_d = S_ERR1;
            end else begin
                live_d = 1'b1;
                if (WAIT_STATES > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end else begin
                    state_d = S_IDLE;
                end
            end
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d  = cnt_q - 4'd1;
                        live_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ERR1:  state_d = S_ERR2;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            live_q  <= 1'b0;
            word_q  <= '0;
            lane_q  <= 2'd0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= live_d;
            if (accept) begin
                word_q  <= offset[AW+1:2];
                lane_q  <= HADDR[1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end
        end
    end

    always_comb begin
        be = 4'b1111;
        case (size_q[1:0])
            2'd0:    be = 4'b0001 << lane_q;
            2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Storage has no reset; a reset in the final write cycle drops the write.
    assign do_write = live_q && ready_c && write_q && !HRESET;

    always_ff @(posedge HCLK) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = ready_c;
    assign HRESP     = resp_c;
    assign HRDATA    = (live_q && ready_c && !write_q) ? mem[word_q] : 32'h0;
endmodule
